// File: rtl/rps_match_controller.sv
// rtl/rps_match_controller.sv - rock-paper-scissors match controller driving a combinational judge
//
// Purpose:
//   Collects one move per player per round, presents both moves to an
//   external combinational judge for one cycle, samples the verdict and
//   keeps a saturating round-win score per player. Declares the match
//   winner once either score reaches WINS_TO_MATCH.
//
// Ports:
//   clock, reset_n          rising-edge clock, asynchronous active-low reset
//   p1_move/p1_valid        player 1 move offer (one-hot rock/paper/scissors)
//   p2_move/p2_valid        player 2 move offer
//   new_match               synchronous match restart, valid in every state
//   player1, player2        registered moves to the judge, 000 when not judging
//   p1wins, p2wins, tied    judge verdict
//   round_done              one-cycle pulse when a round has been scored
//   p1_score, p2_score      round wins per player
//   match_over              level, high while the match is decided
//   match_winner            01 player 1, 10 player 2, 00 none
//   err_move                one-cycle pulse for a non-one-hot move offer
//   err_verdict             one-cycle pulse for a verdict that is not one-hot

module rps_match_controller #(
  parameter int WINS_TO_MATCH = 3,
  parameter int SCORE_W       = 3
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic [2:0]         p1_move,
  input  logic               p1_valid,
  input  logic [2:0]         p2_move,
  input  logic               p2_valid,
  input  logic               new_match,
  output logic [2:0]         player1,
  output logic [2:0]         player2,
  input  logic               p1wins,
  input  logic               p2wins,
  input  logic               tied,
  output logic               round_done,
  output logic [SCORE_W-1:0] p1_score,
  output logic [SCORE_W-1:0] p2_score,
  output logic               match_over,
  output logic [1:0]         match_winner,
  output logic               err_move,
  output logic               err_verdict
);

  localparam logic [1:0] S_COLLECT = 2'd0;
  localparam logic [1:0] S_JUDGE   = 2'd1;
  localparam logic [1:0] S_UPDATE  = 2'd2;
  localparam logic [1:0] S_DONE    = 2'd3;

  localparam logic [SCORE_W-1:0] TARGET = SCORE_W'(WINS_TO_MATCH);

  logic [1:0] state;
  logic [2:0] p1_latch;
  logic [2:0] p2_latch;
  logic       p1_full;
  logic       p2_full;

  function automatic logic is_onehot(input logic [2:0] m);
    return (m == 3'b001) || (m == 3'b010) || (m == 3'b100);
  endfunction

  // Offer qualification. A malformed move is flagged whether or not its
  // latch is free, but it never reaches a latch.
  logic p1_bad, p2_bad;
  logic p1_take, p2_take;
  logic p1_ready, p2_ready;

  always_comb begin
    p1_bad   = p1_valid && !is_onehot(p1_move);
    p2_bad   = p2_valid && !is_onehot(p2_move);
    p1_take  = p1_valid && is_onehot(p1_move) && !p1_full;
    p2_take  = p2_valid && is_onehot(p2_move) && !p2_full;
    p1_ready = p1_full || p1_take;
    p2_ready = p2_full || p2_take;
  end

  // Verdict decode. Anything other than exactly one asserted verdict line
  // scores as a tie and raises err_verdict.
  logic v_p1, v_p2, v_tie, v_bad;

  always_comb begin
    v_p1  =  p1wins && !p2wins && !tied;
    v_p2  = !p1wins &&  p2wins && !tied;
    v_tie = !p1wins && !p2wins &&  tied;
    v_bad = !(v_p1 || v_p2 || v_tie);
  end

  logic p1_at_target, p2_at_target;

  always_comb begin
    p1_at_target = (p1_score == TARGET);
    p2_at_target = (p2_score == TARGET);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state        <= S_COLLECT;
      p1_latch     <= 3'b000;
      p2_latch     <= 3'b000;
      p1_full      <= 1'b0;
      p2_full      <= 1'b0;
      player1      <= 3'b000;
      player2      <= 3'b000;
      round_done   <= 1'b0;
      p1_score     <= '0;
      p2_score     <= '0;
      match_over   <= 1'b0;
      match_winner <= 2'b00;
      err_move     <= 1'b0;
      err_verdict  <= 1'b0;
    end else begin
      // Pulses are single-cycle unless re-asserted below.
      round_done  <= 1'b0;
      err_move    <= 1'b0;
      err_verdict <= 1'b0;

      if (new_match) begin
        state        <= S_COLLECT;
        p1_latch     <= 3'b000;
        p2_latch     <= 3'b000;
        p1_full      <= 1'b0;
        p2_full      <= 1'b0;
        player1      <= 3'b000;
        player2      <= 3'b000;
        p1_score     <= '0;
        p2_score     <= '0;
        match_over   <= 1'b0;
        match_winner <= 2'b00;
      end else begin
        case (state)
          S_COLLECT: begin
            err_move <= p1_bad || p2_bad;
            if (p1_take) begin
              p1_latch <= p1_move;
              p1_full  <= 1'b1;
            end
            if (p2_take) begin
              p2_latch <= p2_move;
              p2_full  <= 1'b1;
            end
            // Moves go to the judge on the same edge the second latch fills,
            // so they are visible for exactly the JUDGE cycle.
            if (p1_ready && p2_ready) begin
              state   <= S_JUDGE;
              player1 <= p1_take ? p1_move : p1_latch;
              player2 <= p2_take ? p2_move : p2_latch;
            end
          end

          S_JUDGE: begin
            player1 <= 3'b000;
            player2 <= 3'b000;
            if (v_p1 && (p1_score < TARGET)) begin
              p1_score <= p1_score + 1'b1;
            end
            if (v_p2 && (p2_score < TARGET)) begin
              p2_score <= p2_score + 1'b1;
            end
            err_verdict <= v_bad;
            round_done  <= 1'b1;
            state       <= S_UPDATE;
          end

          S_UPDATE: begin
            if (p1_at_target || p2_at_target) begin
              state        <= S_DONE;
              match_over   <= 1'b1;
              match_winner <= p1_at_target ? 2'b01 : 2'b10;
            end else begin
              p1_latch <= 3'b000;
              p2_latch <= 3'b000;
              p1_full  <= 1'b0;
              p2_full  <= 1'b0;
              state    <= S_COLLECT;
            end
          end

          S_DONE: begin
            // Holds until new_match; offers are ignored.
            state <= S_DONE;
          end

          default: begin
            state <= S_COLLECT;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rps_match_controller.sv
// tb/tb_rps_match_controller.sv - scoreboard testbench for rps_match_controller

module tb_rps_match_controller;

  logic       clock;
  logic       reset_n;
  logic [2:0] p1_move, p2_move;
  logic       p1_valid, p2_valid;
  logic       new_match;
  logic [2:0] player1, player2;
  logic       p1wins, p2wins, tied;
  logic       round_done;
  logic [2:0] p1_score, p2_score;
  logic       match_over;
  logic [1:0] match_winner;
  logic       err_move, err_verdict;

  rps_match_controller #(.WINS_TO_MATCH(3), .SCORE_W(3)) dut (
    .clock(clock), .reset_n(reset_n),
    .p1_move(p1_move), .p1_valid(p1_valid),
    .p2_move(p2_move), .p2_valid(p2_valid),
    .new_match(new_match),
    .player1(player1), .player2(player2),
    .p1wins(p1wins), .p2wins(p2wins), .tied(tied),
    .round_done(round_done),
    .p1_score(p1_score), .p2_score(p2_score),
    .match_over(match_over), .match_winner(match_winner),
    .err_move(err_move), .err_verdict(err_verdict)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // External judge: rock 001 beats scissors 100, paper 010 beats rock,
  // scissors beats paper. force_en overrides with a raw verdict.
  logic       force_en;
  logic [2:0] force_val;

  function automatic logic beats(input logic [2:0] a, input logic [2:0] b);
    return (a == 3'b001 && b == 3'b100) || (a == 3'b010 && b == 3'b001) ||
           (a == 3'b100 && b == 3'b010);
  endfunction

  always_comb begin
    if (force_en) begin
      {p1wins, p2wins, tied} = force_val;
    end else begin
      p1wins = beats(player1, player2);
      p2wins = beats(player2, player1);
      tied   = (player1 == player2) && (player1 != 3'b000);
    end
  end

  localparam int K_JUDGE = 0;
  localparam int K_ROUND = 1;
  localparam int K_ERR   = 2;

  typedef struct {
    int kind;
    int a;
    int b;
    int c;
  } ev_t;

  ev_t q[$];
  int  n_cmp = 0;
  int  n_bad = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input int kind, input int a, input int b, input int c);
    ev_t e;
    e.kind = kind; e.a = a; e.b = b; e.c = c;
    q.push_back(e);
  endtask

  task automatic take(input int kind, input int a, input int b, input int c);
    ev_t e;
    if (q.size() == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL unexpected_output: kind %0d (%0d,%0d,%0d) with empty scoreboard at %0t",
               kind, a, b, c, $time);
    end else begin
      e = q.pop_front();
      chk("event_kind", kind, e.kind);
      chk("event_a", a, e.a);
      chk("event_b", b, e.b);
      chk("event_c", c, e.c);
    end
  endtask

  // Monitor: samples on the falling edge, away from the active edge.
  always @(negedge clock) begin
    if (reset_n) begin
      if (player1 != 3'b000 || player2 != 3'b000)
        take(K_JUDGE, int'(player1), int'(player2), 0);
      if (round_done)
        take(K_ROUND, int'(p1_score), int'(p2_score), int'(err_verdict));
      if (err_move)
        take(K_ERR, 0, 0, 0);
      if (err_verdict && !round_done)
        take(K_ERR, 1, 1, 1);
    end
  end

  task automatic offer(input logic v1, input logic [2:0] m1,
                       input logic v2, input logic [2:0] m2);
    @(posedge clock); #1;
    p1_valid = v1; p1_move = m1;
    p2_valid = v2; p2_move = m2;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock); #1;
      p1_valid = 1'b0; p2_valid = 1'b0;
      p1_move = 3'b000; p2_move = 3'b000;
    end
  endtask

  task automatic play(input logic [2:0] m1, input logic [2:0] m2,
                      input int s1, input int s2);
    push(K_JUDGE, int'(m1), int'(m2), 0);
    push(K_ROUND, s1, s2, 0);
    offer(1'b1, m1, 1'b1, m2);
    idle(3);
  endtask

  initial begin
    reset_n = 1'b0; new_match = 1'b0;
    p1_valid = 1'b0; p2_valid = 1'b0; p1_move = 3'b000; p2_move = 3'b000;
    force_en = 1'b0; force_val = 3'b000;
    repeat (3) @(posedge clock);
    #1 reset_n = 1'b1;
    @(negedge clock);
    chk("reset_player1", int'(player1), 0);
    chk("reset_player2", int'(player2), 0);
    chk("reset_p1_score", int'(p1_score), 0);
    chk("reset_p2_score", int'(p2_score), 0);
    chk("reset_match_over", int'(match_over), 0);
    chk("reset_round_done", int'(round_done), 0);

    // Rock vs scissors, both offered together.
    play(3'b001, 3'b100, 1, 0);

    // Paper then paper two cycles later; the interim p1 scissors is ignored.
    push(K_JUDGE, 2, 2, 0);
    push(K_ROUND, 1, 0, 0);
    offer(1'b1, 3'b010, 1'b0, 3'b000);
    offer(1'b1, 3'b100, 1'b0, 3'b000);
    offer(1'b0, 3'b000, 1'b1, 3'b010);
    idle(3);

    // Player 2 wins three rounds with paper over rock.
    play(3'b001, 3'b010, 1, 1);
    play(3'b001, 3'b010, 1, 2);
    play(3'b001, 3'b010, 1, 3);
    chk("done_match_over", int'(match_over), 1);
    chk("done_match_winner", int'(match_winner), 2);
    offer(1'b1, 3'b001, 1'b1, 3'b100);
    idle(4);
    chk("done_hold_p2_score", int'(p2_score), 3);
    chk("done_hold_match_over", int'(match_over), 1);
    @(posedge clock); #1 new_match = 1'b1;
    @(posedge clock); #1 new_match = 1'b0;
    chk("restart_p1_score", int'(p1_score), 0);
    chk("restart_p2_score", int'(p2_score), 0);
    chk("restart_match_over", int'(match_over), 0);
    chk("restart_match_winner", int'(match_winner), 0);

    // Malformed p1 move alongside a valid p2 move: only p2 latches.
    push(K_ERR, 0, 0, 0);
    offer(1'b1, 3'b011, 1'b1, 3'b100);
    idle(3);
    // Bad verdict 110 scores as a tie with err_verdict.
    force_en = 1'b1; force_val = 3'b110;
    push(K_JUDGE, 1, 4, 0);
    push(K_ROUND, 0, 0, 1);
    offer(1'b1, 3'b001, 1'b0, 3'b000);
    idle(3);
    force_en = 1'b0;

    // Reset asserted during JUDGE clears everything and no round follows.
    play(3'b001, 3'b100, 1, 0);
    offer(1'b1, 3'b001, 1'b1, 3'b100);
    @(posedge clock); #2;
    reset_n = 1'b0;
    p1_valid = 1'b0; p2_valid = 1'b0;
    #1;
    chk("async_reset_player1", int'(player1), 0);
    chk("async_reset_player2", int'(player2), 0);
    chk("async_reset_p1_score", int'(p1_score), 0);
    @(posedge clock); #1 reset_n = 1'b1;
    idle(5);
    chk("post_reset_p1_score", int'(p1_score), 0);
    chk("post_reset_round_done", int'(round_done), 0);

    idle(3);
    chk("scoreboard_drained", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
